// File: rtl/gpi_conditioner.sv
// rtl/gpi_conditioner.sv - per-channel GPI polarity fix, 2-flop sync, debounce, edge pulses, sticky events
// Optional sticky events and interrupt built when GPI_CONDITIONER_EVT_EN is defined.
module gpi_conditioner #(
  parameter int unsigned      Width          = 13,
  parameter int unsigned      DebounceCycles = 50000,
  parameter logic [Width-1:0] InvertMask     = {Width{1'b1}},
  parameter logic [Width-1:0] RiseEvtMask    = {Width{1'b1}},
  parameter logic [Width-1:0] FallEvtMask    = {Width{1'b0}}
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] evt_o,
  input  logic [Width-1:0] evt_clr_i,
  output logic             irq_o
);

  localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;
  logic [CntW-1:0]  cnt_q [Width];

  // Polarity is fixed before the synchroniser so reset-state 0 always means "off".
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gp_raw_i ^ InvertMask;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gp_o   <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < int'(Width); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Width); i++) begin
        rise_o[i] <= 1'b0;
        fall_o[i] <= 1'b0;
        if (sync2_q[i] == gp_o[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          gp_o[i]   <= sync2_q[i];
          rise_o[i] <= sync2_q[i];
          fall_o[i] <= ~sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

`ifdef GPI_CONDITIONER_EVT_EN
  logic [Width-1:0] evt_q;

  // A set from a same-cycle edge pulse overrides a write-1-to-clear.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~evt_clr_i) | (rise_o & RiseEvtMask) | (fall_o & FallEvtMask);
    end
  end

  assign evt_o = evt_q;
  assign irq_o = |evt_q;
`else
  logic [Width-1:0] unused_evt_clr;
  assign unused_evt_clr = evt_clr_i;

  assign evt_o = '0;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_conditioner.sv
// tb/tb_gpi_conditioner.sv - directed and randomized bench for gpi_conditioner against a window-based reference model
module tb_gpi_conditioner;

  localparam int         W   = 4;
  localparam int         D   = 4;
  localparam logic [3:0] INV = 4'b0011;
  localparam logic [3:0] RM  = 4'b1111;
  localparam logic [3:0] FM  = 4'b0100;
`ifdef GPI_CONDITIONER_EVT_EN
  localparam logic EVT_EN = 1'b1;
`else
  localparam logic EVT_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] raw   = 4'b0011;
  logic [3:0] clr   = 4'b0000;
  logic [3:0] gp, rise, fall, evt;
  logic       irq;

  always #5 clk = ~clk;

  gpi_conditioner #(
    .Width(W), .DebounceCycles(D), .InvertMask(INV), .RiseEvtMask(RM), .FallEvtMask(FM)
  ) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .gp_raw_i(raw), .gp_o(gp),
    .rise_o(rise), .fall_o(fall), .evt_o(evt), .evt_clr_i(clr), .irq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: s is the inverted input delayed by two edges; a channel flips when the
  // last D pre-edge samples of s all disagree with its accepted level.
  logic [3:0] pq[$];
  logic [3:0] sh[$];
  logic [3:0] m_gp, m_rise, m_fall, m_evt;

  function automatic void model_clear();
    pq.delete();
    pq.push_back(4'h0);
    pq.push_back(4'h0);
    sh.delete();
    m_gp   = 4'h0;
    m_rise = 4'h0;
    m_fall = 4'h0;
    m_evt  = 4'h0;
  endfunction

  function automatic void model_edge();
    logic [3:0] flip;
    logic       all_diff;
    flip = 4'h0;
    sh.push_back(pq[0]);
    if (sh.size() > D) void'(sh.pop_front());
    if (sh.size() == D) begin
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        foreach (sh[k]) if (sh[k][i] == m_gp[i]) all_diff = 1'b0;
        flip[i] = all_diff;
      end
    end
    if (EVT_EN) m_evt = (m_evt & ~clr) | (m_rise & RM) | (m_fall & FM);
    else        m_evt = 4'h0;
    m_rise = flip & ~m_gp;
    m_fall = flip & m_gp;
    m_gp   = m_gp ^ flip;
    void'(pq.pop_front());
    pq.push_back(raw ^ INV);
  endfunction

  task automatic check_all();
    check("gp", gp, m_gp);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("evt", evt, m_evt);
    check("irq", irq, |m_evt);
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_all();
    tick();
    rst_n = 1'b1;
  endtask

  int hold [W];
  int lat;

  initial begin
    model_clear();
    // 1: reset with arbitrary inputs, release with all channels off
    raw = 4'($urandom);
    #1 rst_n = 1'b0;
    #1 check_all();
    ticks(2);
    raw = 4'b0011;
    rst_n = 1'b1;
    ticks(8);
    check("idle_gp", gp, 4'h0);

    // 2: clean press on ch2
    raw[2] = 1'b1;
    ticks(5);
    check("press_gp_early", gp[2], 1'b0);
    tick();
    check("press_gp", gp[2], 1'b1);
    check("press_rise", rise[2], 1'b1);
    tick();
    check("press_evt", evt[2], EVT_EN);
    check("press_irq", irq, EVT_EN);

    // 3: bounce on ch3 with 3-cycle levels
    for (int k = 0; k < 4; k++) begin
      raw[3] = (k % 2 == 0);
      ticks(3);
    end
    ticks(6);
    check("bounce_gp", gp[3], 1'b0);
    check("bounce_evt", evt[3], 1'b0);

    // 4: inverted ch0, rise sets event, fall does not
    raw[0] = 1'b0;
    ticks(6);
    check("inv_gp", gp[0], 1'b1);
    check("inv_rise", rise[0], 1'b1);
    tick();
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    check("inv_clr", evt[0], 1'b0);
    raw[0] = 1'b1;
    ticks(6);
    check("inv_fall", fall[0], 1'b1);
    tick();
    check("inv_fall_noevt", evt[0], 1'b0);

    // 5a: plain clear
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    check("clr_evt", evt[2], 1'b0);
    check("clr_irq", irq, 1'b0);

    // 5b: clear coinciding with a ch2 fall
    raw[2] = 1'b0;
    ticks(7);
    raw[2] = 1'b1;
    ticks(7);
    raw[2] = 1'b0;
    ticks(6);
    check("setclr_fall", fall[2], 1'b1);
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    check("setclr_evt", evt[2], EVT_EN);

    // 6: reset mid-count on ch1
    raw[1] = 1'b0;
    ticks(5);
    check("midcnt_gp", gp[1], 1'b0);
    async_reset();
    check("midrst_gp", gp[1], 1'b0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rise[1]) begin
        lat = n;
        break;
      end
    end
    check("rerise_lat", lat, 6);

    // randomized phase
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          raw[i]  = 1'($urandom);
          hold[i] = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpi_conditioner.md
# gpi_conditioner

Parametrised N-channel general-purpose input conditioner for board switches and buttons. It sits between the FPGA top-level pins and the `gp_i` input of `ibex_demo_system`. Per channel it provides polarity correction, two-flop synchronisation, counter-based debounce, rise/fall edge pulses and sticky edge events. A single interrupt line is driven from the sticky events.

## Interface

Parameters:
- `Width`, 13: number of input channels; must be ≥ 1.
- `DebounceCycles`, 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz); must be ≥ 1.
- `InvertMask`, `{Width{1'b1}}`: bit i = 1 inverts channel i (active-low pull-up switch). Logical "on" is always 1.
- `RiseEvtMask`, `{Width{1'b1}}`: bit i = 1 means a rising edge on channel i sets `evt_o[i]`.
- `FallEvtMask`, `{Width{1'b0}}`: bit i = 1 means a falling edge on channel i sets `evt_o[i]`.

Ports:
- `clk_sys_i`  in  1  system clock.
- `rst_sys_ni`  in  1  asynchronous active-low reset.
- `gp_raw_i`  in  Width  raw asynchronous pad inputs.
- `gp_o`  out  Width  debounced, polarity-corrected levels.
- `rise_o`  out  Width  one-cycle pulse on an accepted 0→1 transition.
- `fall_o`  out  Width  one-cycle pulse on an accepted 1→0 transition.
- `evt_o`  out  Width  sticky edge events.
- `evt_clr_i`  in  Width  write-1-to-clear for `evt_o`, per bit, sampled every cycle.
- `irq_o`  out  1  OR of all `evt_o` bits.

## Operation

- Inversion: `p[i] = gp_raw_i[i] ^ InvertMask[i]`. This is combinational and applied before synchronisation.
- Synchronisation: two flops per channel produce `s[i]`. Both flops reset to 0, so all inputs read "off" at reset.
- Debounce: each channel has a counter of width `$clog2(DebounceCycles+1)` and holds the accepted level in `gp_o[i]`. Every clock edge:
  - If `s[i] == gp_o[i]`: `cnt <= 0`.
  - Else if `cnt == DebounceCycles-1`: `gp_o[i] <= s[i]`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- A glitch shorter than `DebounceCycles` cycles at the synchroniser output is discarded and the counter restarts from 0. The counter never wraps.
- Edge pulses: `rise_o` and `fall_o` are registered on the same edge as the `gp_o` update.
  - `rise_o[i]` is 1 for exactly one cycle when `gp_o[i]` goes 0→1.
  - `fall_o[i]` is 1 for exactly one cycle when `gp_o[i]` goes 1→0.
  - Both can never be high together on one channel.
- Events: on each edge, `evt_o[i] <= (evt_o[i] & ~evt_clr_i[i]) | (rise_o[i] & RiseEvtMask[i]) | (fall_o[i] & FallEvtMask[i])`. When a set and a clear coincide, the set wins.
- `irq_o = |evt_o`. This is combinational from flops and level-sensitive.
- Channels are fully independent; there is no cross-channel arbitration.

## Timing

- Reset values: `gp_o`, `rise_o`, `fall_o`, `evt_o` = 0; `irq_o` = 0. Sync flops and counters are also 0.
- Latency from an input change sampled at edge 0:
  - `s` changes at edge 2.
  - `gp_o` and the rise/fall pulse update at edge `2+DebounceCycles`.
  - `evt_o` sets at edge `3+DebounceCycles`, and `irq_o` rises in the same cycle.
- With `DebounceCycles=1`, `gp_o` follows `s` with 1 cycle of delay and filters nothing.
- Reset mid-debounce: counters and accepted levels return to 0 immediately and asynchronously. After reset release, a held "on" input is re-accepted after 2+DebounceCycles cycles and generates a rise.
- `evt_clr_i` takes effect on the next edge. `irq_o` drops in that cycle if no other event bit is set.

## Configuration

- `GPI_CONDITIONER_EVT_EN`:
  - Defined: the sticky event registers and the interrupt are built as described above.
  - Undefined: no event flops are built; `evt_o` and `irq_o` are tied to 0 and `evt_clr_i` is ignored. `gp_o`, `rise_o` and `fall_o` are unchanged.

## Test plan

All scenarios use Width=4, DebounceCycles=4, InvertMask=4'b0011, RiseEvtMask=4'b1111, FallEvtMask=4'b0100, with `GPI_CONDITIONER_EVT_EN` defined.

1. Reset: assert reset with arbitrary raw inputs → all outputs are 0. Release reset with `gp_raw_i=4'b0011` → `gp_o` stays 0, with no pulses and no irq.
2. Clean press: ch2 raw goes 0→1 at edge 0 →
   - `gp_o[2]=1` and a `rise_o[2]` pulse at edge 6.
   - `evt_o[2]=1` and `irq_o=1` at edge 7.
3. Bounce rejection: ch3 raw toggles 1,0,1,0 with each level held 3 cycles → `gp_o[3]`, `rise_o[3]` and `evt_o[3]` stay 0.
4. Inversion: ch0 raw 1→0 → `gp_o[0]` goes 0→1 at +6 cycles with `rise_o[0]`. Raw back 0→1 → `fall_o[0]` pulses, and `evt_o[0]` does not set on the fall because its FallEvtMask bit is 0.
5. Clear versus set:
   - With `evt_o[2]=1`, pulse `evt_clr_i=4'b0100` → `evt_o[2]=0` and `irq_o=0` next cycle.
   - Repeat with the clear coinciding with a ch2 fall edge → `evt_o[2]` remains 1.
6. Reset mid-count: ch1 raw active for 3 synchronised cycles, then assert reset → `gp_o[1]=0`. Release with ch1 still active → rise after 6 cycles.
